// File: rtl/run_monitor_if.sv
// run_monitor_if: processor probe, checkpoint table and run-status bundle.
// master drives pc/disp_dat/chk_*/start/clear; slave (monitor) drives status.
interface run_monitor_if #(
  parameter int WIDTH   = 32,
  parameter int ADDR_W  = 8,
  parameter int NUM_CHK = 4
);
  localparam int IDX_W = (NUM_CHK > 1) ? $clog2(NUM_CHK) : 1;

  logic [WIDTH-1:0]          pc;
  logic [WIDTH-1:0]          disp_dat;
  logic [NUM_CHK*ADDR_W-1:0] chk_pc;
  logic [NUM_CHK*WIDTH-1:0]  chk_val;
  logic                      start;
  logic                      clear;
  logic [2:0]                state;
  logic                      done;
  logic                      pass;
  logic                      fail;
  logic [1:0]                fail_code;
  logic [IDX_W-1:0]          fail_idx;
  logic [WIDTH-1:0]          got_val;
  logic [WIDTH-1:0]          cycle_cnt;

  modport master (
    output pc, disp_dat, chk_pc, chk_val, start, clear,
    input  state, done, pass, fail, fail_code, fail_idx,
    input  got_val, cycle_cnt
  );

  modport slave (
    input  pc, disp_dat, chk_pc, chk_val, start, clear,
    output state, done, pass, fail, fail_code, fail_idx,
    output got_val, cycle_cnt
  );
endinterface

// File: rtl/run_monitor.sv
// run_monitor: walks an ordered checkpoint table against the processor PC
// and display data, reporting pass / mismatch / (optional) watchdog timeout.
// Ports: clk, reset (async active-low), bus (run_monitor_if.slave):
//   in  pc, disp_dat, chk_pc, chk_val, start, clear
//   out state, done, pass, fail, fail_code, fail_idx, got_val, cycle_cnt
// Optional: define RUN_MON_TIMEOUT_EN to enable the TIMEOUT watchdog.
module run_monitor #(
  parameter int WIDTH   = 32,
  parameter int ADDR_W  = 8,
  parameter int NUM_CHK = 4,
  parameter int TIMEOUT = 1000
) (
  input  logic          clk,
  input  logic          reset,
  run_monitor_if.slave  bus
);
  localparam int IDX_W = (NUM_CHK > 1) ? $clog2(NUM_CHK) : 1;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RUN  = 3'd1,
    S_PASS = 3'd2,
    S_FAIL = 3'd3
  } state_t;

  if (NUM_CHK < 1 || NUM_CHK > 16 || TIMEOUT < 1 ||
      ADDR_W > WIDTH) begin : g_bad_cfg
    $error("run_monitor: bad parameters");
  end

  state_t           r_state;
  logic [IDX_W-1:0] r_idx;
  logic [WIDTH-1:0] r_cnt;
  logic [1:0]       r_code;
  logic [IDX_W-1:0] r_fidx;
  logic [WIDTH-1:0] r_got;
  logic             r_done;
  logic             r_pass;
  logic             r_fail;

  state_t           w_nxt;
  logic [IDX_W-1:0] w_idx;
  logic [WIDTH-1:0] w_cnt;
  logic [1:0]       w_code;
  logic [IDX_W-1:0] w_fidx;
  logic [WIDTH-1:0] w_got;
  logic [ADDR_W-1:0] w_cpc;
  logic [WIDTH-1:0] w_cval;
  logic             w_hit;
  logic             w_match;
  logic             w_last;

  if (ADDR_W < WIDTH) begin : g_pc_hi
    logic w_pc_unused;
    assign w_pc_unused = ^bus.pc[WIDTH-1:ADDR_W];
  end

  // Only the current checkpoint entry is ever compared.
  always_comb begin
    w_cpc  = '0;
    w_cval = '0;
    for (int i = 0; i < NUM_CHK; i++) begin
      if (r_idx == IDX_W'(i)) begin
        w_cpc  = bus.chk_pc[i*ADDR_W +: ADDR_W];
        w_cval = bus.chk_val[i*WIDTH +: WIDTH];
      end
    end
  end

  assign w_hit   = (bus.pc[ADDR_W-1:0] == w_cpc);
  assign w_match = (bus.disp_dat == w_cval);
  assign w_last  = (r_idx == IDX_W'(NUM_CHK-1));

  always_comb begin
    w_nxt  = r_state;
    w_idx  = r_idx;
    w_cnt  = r_cnt;
    w_code = r_code;
    w_fidx = r_fidx;
    w_got  = r_got;
    unique case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_nxt  = S_RUN;
          w_idx  = '0;
          w_cnt  = '0;
          w_code = 2'd0;
          w_fidx = '0;
          w_got  = '0;
        end
      end
      S_RUN: begin
        w_cnt = (&r_cnt) ? r_cnt : r_cnt + 1'b1;
        if (w_hit) begin
          if (!w_match) begin
            w_nxt  = S_FAIL;
            w_code = 2'd1;
            w_fidx = r_idx;
            w_got  = bus.disp_dat;
          end else if (w_last) begin
            w_nxt = S_PASS;
          end else begin
            w_idx = r_idx + 1'b1;
          end
        end
`ifdef RUN_MON_TIMEOUT_EN
        // A hit in the limit cycle wins over the watchdog.
        else if (r_cnt == WIDTH'(TIMEOUT-1)) begin
          w_nxt  = S_FAIL;
          w_code = 2'd2;
          w_fidx = r_idx;
        end
`endif
      end
      S_PASS, S_FAIL: begin
        if (bus.clear) w_nxt = S_IDLE;
      end
      default: w_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_cnt   <= '0;
      r_code  <= 2'd0;
      r_fidx  <= '0;
      r_got   <= '0;
      r_done  <= 1'b0;
      r_pass  <= 1'b0;
      r_fail  <= 1'b0;
    end else begin
      r_state <= w_nxt;
      r_idx   <= w_idx;
      r_cnt   <= w_cnt;
      r_code  <= w_code;
      r_fidx  <= w_fidx;
      r_got   <= w_got;
      r_done  <= (w_nxt == S_PASS) || (w_nxt == S_FAIL);
      r_pass  <= (w_nxt == S_PASS);
      r_fail  <= (w_nxt == S_FAIL);
    end
  end

  assign bus.state     = r_state;
  assign bus.done      = r_done;
  assign bus.pass      = r_pass;
  assign bus.fail      = r_fail;
  assign bus.fail_code = r_code;
  assign bus.fail_idx  = r_fidx;
  assign bus.got_val   = r_got;
  assign bus.cycle_cnt = r_cnt;
endmodule

// File: tb/tb_run_monitor.sv
// tb_run_monitor: directed vectors with a queue scoreboard per instance;
// monitors pop an expected terminal result whenever done rises.
module tb_run_monitor;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  run_monitor_if #(.WIDTH(32), .ADDR_W(8), .NUM_CHK(1)) b1();
  run_monitor_if #(.WIDTH(32), .ADDR_W(8), .NUM_CHK(2)) b2();

  run_monitor #(.WIDTH(32), .ADDR_W(8), .NUM_CHK(1), .TIMEOUT(100))
    u1 (.clk(clk), .reset(reset), .bus(b1.slave));
  run_monitor #(.WIDTH(32), .ADDR_W(8), .NUM_CHK(2), .TIMEOUT(100))
    u2 (.clk(clk), .reset(reset), .bus(b2.slave));

  typedef struct {
    logic [2:0]  st;
    logic [1:0]  code;
    logic [31:0] idx;
    logic [31:0] got;
    logic [31:0] cnt;
    string       tag;
  } exp_t;

  exp_t q1[$];
  exp_t q2[$];
  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  task automatic cmp(input exp_t e, input logic [2:0] st, input logic p,
                     input logic f, input logic [1:0] code,
                     input logic [31:0] idx, input logic [31:0] got,
                     input logic [31:0] cnt);
    chk({e.tag, "_state"}, 32'(st), 32'(e.st));
    chk({e.tag, "_pass"}, 32'(p), 32'(e.st == 3'd2));
    chk({e.tag, "_fail"}, 32'(f), 32'(e.st == 3'd3));
    chk({e.tag, "_code"}, 32'(code), 32'(e.code));
    chk({e.tag, "_idx"}, idx, e.idx);
    chk({e.tag, "_got"}, got, e.got);
    chk({e.tag, "_cnt"}, cnt, e.cnt);
  endtask

  logic d1q = 1'b0;
  logic d2q = 1'b0;

  always @(negedge clk) begin
    if (b1.done && !d1q) begin
      if (q1.size() == 0) begin
        total++; bad++;
        $display("FAIL u1_unexpected_done got=1 want=0");
      end else begin
        cmp(q1.pop_front(), b1.state, b1.pass, b1.fail, b1.fail_code,
            32'(b1.fail_idx), b1.got_val, b1.cycle_cnt);
      end
    end
    d1q = b1.done;
  end

  always @(negedge clk) begin
    if (b2.done && !d2q) begin
      if (q2.size() == 0) begin
        total++; bad++;
        $display("FAIL u2_unexpected_done got=1 want=0");
      end else begin
        cmp(q2.pop_front(), b2.state, b2.pass, b2.fail, b2.fail_code,
            32'(b2.fail_idx), b2.got_val, b2.cycle_cnt);
      end
    end
    d2q = b2.done;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic u1_start();
    b1.start = 1'b1;
    tick();
    b1.start = 1'b0;
  endtask

  task automatic u1_clear();
    b1.clear = 1'b1;
    tick();
    b1.clear = 1'b0;
  endtask

  task automatic u2_start();
    b2.start = 1'b1;
    tick();
    b2.start = 1'b0;
  endtask

  task automatic u2_clear();
    b2.clear = 1'b1;
    tick();
    b2.clear = 1'b0;
  endtask

  // Three non-hit cycles at 0x0C then one hit cycle at 0x10.
  task automatic u1_seq(input logic [31:0] dv);
    b1.pc = 32'h0C;
    repeat (3) tick();
    b1.pc = 32'h10;
    b1.disp_dat = dv;
    tick();
    b1.pc = 32'h0C;
  endtask

  initial begin
    reset = 1'b0;
    b1.pc = '0; b1.disp_dat = '0; b1.chk_pc = '0; b1.chk_val = '0;
    b1.start = 1'b0; b1.clear = 1'b0;
    b2.pc = '0; b2.disp_dat = '0; b2.chk_pc = '0; b2.chk_val = '0;
    b2.start = 1'b0; b2.clear = 1'b0;
    #12;
    chk("rst_state", 32'(b1.state), 0);
    chk("rst_done", 32'(b1.done), 0);
    chk("rst_cnt", b1.cycle_cnt, 0);
    @(negedge clk);
    reset = 1'b1;
    repeat (2) tick();
    chk("no_auto_start", 32'(b1.state), 0);

    b1.chk_pc  = 8'h10;
    b1.chk_val = 32'd24;

    q1.push_back('{3'd2, 2'd0, 32'd0, 32'd0, 32'd4, "pass1"});
    u1_start();
    chk("run_entered", 32'(b1.state), 1);
    u1_seq(32'd24);

    b1.start = 1'b1;
    tick();
    b1.start = 1'b0;
    chk("start_in_pass_state", 32'(b1.state), 2);
    chk("start_in_pass_cnt", b1.cycle_cnt, 4);
    u1_clear();
    chk("clear_to_idle", 32'(b1.state), 0);

    q1.push_back('{3'd2, 2'd0, 32'd0, 32'd0, 32'd4, "pass2"});
    u1_start();
    u1_seq(32'd24);
    u1_clear();

    q1.push_back('{3'd3, 2'd1, 32'd0, 32'd23, 32'd4, "mism"});
    u1_start();
    b1.clear = 1'b1;
    b1.pc = 32'h0C;
    tick();
    b1.clear = 1'b0;
    chk("clear_in_run", 32'(b1.state), 1);
    repeat (2) tick();
    b1.pc = 32'h10;
    b1.disp_dat = 32'd23;
    tick();
    b1.pc = 32'h0C;
    u1_clear();

`ifdef RUN_MON_TIMEOUT_EN
    q1.push_back('{3'd3, 2'd2, 32'd0, 32'd0, 32'd100, "tmo"});
`endif
    u1_start();
    b1.pc = 32'h0C;
    repeat (120) tick();
`ifndef RUN_MON_TIMEOUT_EN
    chk("no_tmo_state", 32'(b1.state), 1);
    chk("no_tmo_cnt", b1.cycle_cnt, 120);
    chk("no_tmo_code", 32'(b1.fail_code), 0);
`endif
    reset = 1'b0;
    #1;
    reset = 1'b1;
    tick();

    b2.chk_pc  = {8'h20, 8'h10};
    b2.chk_val = {32'd7, 32'd24};
    q2.push_back('{3'd2, 2'd0, 32'd0, 32'd0, 32'd3, "order"});
    u2_start();
    b2.pc = 32'h20; b2.disp_dat = 32'd7;
    tick();
    chk("ooo_ignored", 32'(b2.state), 1);
    b2.pc = 32'h10; b2.disp_dat = 32'd24;
    tick();
    b2.pc = 32'h20; b2.disp_dat = 32'd7;
    tick();
    b2.pc = 32'h0;
    u2_clear();

    q2.push_back('{3'd3, 2'd1, 32'd1, 32'd9, 32'd2, "mism1"});
    u2_start();
    b2.pc = 32'h10; b2.disp_dat = 32'd24;
    tick();
    b2.pc = 32'h20; b2.disp_dat = 32'd9;
    tick();
    b2.pc = 32'h0;
    u2_clear();

    b2.chk_pc = {8'h10, 8'h10};
    q2.push_back('{3'd2, 2'd0, 32'd0, 32'd0, 32'd2, "samepc"});
    u2_start();
    b2.pc = 32'h10; b2.disp_dat = 32'd24;
    tick();
    chk("samepc_still_run", 32'(b2.state), 1);
    b2.disp_dat = 32'd7;
    tick();
    b2.pc = 32'h0;
    u2_clear();

    b2.chk_pc = {8'h20, 8'h10};
    q2.push_back('{3'd2, 2'd0, 32'd0, 32'd0, 32'd101, "hitwins"});
    u2_start();
    b2.pc = 32'h0C;
    repeat (99) tick();
    b2.pc = 32'h10; b2.disp_dat = 32'd24;
    tick();
    chk("hitwins_run", 32'(b2.state), 1);
    b2.pc = 32'h20; b2.disp_dat = 32'd7;
    tick();
    b2.pc = 32'h0;
    u2_clear();

    u1_start();
    b1.pc = 32'h0C;
    repeat (5) tick();
    chk("pre_rst_state", 32'(b1.state), 1);
    chk("pre_rst_cnt", b1.cycle_cnt, 5);
    reset = 1'b0;
    #1;
    chk("arst_state", 32'(b1.state), 0);
    chk("arst_cnt", b1.cycle_cnt, 0);
    chk("arst_flags", {29'd0, b1.done, b1.pass, b1.fail}, 0);
    chk("arst_fail_info",
        {29'd0, b1.fail_code, b1.fail_idx} | b1.got_val, 0);
    @(negedge clk);
    reset = 1'b1;
    repeat (2) tick();
    chk("post_rst_idle", 32'(b1.state), 0);

    repeat (2) tick();
    chk("q1_drained", q1.size(), 0);
    chk("q2_drained", q2.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/run_monitor.md
RUN_MONITOR -- requirements
Module: run_monitor

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data and PC width.
REQ-002 SHALL have parameter ADDR_W, default 8, number of low PC bits compared.
REQ-003 SHALL have parameter NUM_CHK, default 4, number of checkpoints (1..16); IDX_W = max(1, clog2(NUM_CHK)).
REQ-004 SHALL have parameter TIMEOUT, default 1000, watchdog limit in cycles.
REQ-005 SHALL have port clk  in  1  single clock; all state updates on its rising edge.
REQ-006 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-007 SHALL have port pc  in  WIDTH  processor program counter.
REQ-008 SHALL have port disp_dat  in  WIDTH  processor display data.
REQ-009 SHALL have port chk_pc  in  NUM_CHK*ADDR_W  checkpoint addresses; entry i occupies bits [i*ADDR_W +: ADDR_W].
REQ-010 SHALL have port chk_val  in  NUM_CHK*WIDTH  expected disp_dat per checkpoint; same packing.
REQ-011 SHALL have port start  in  1  begins a run.
REQ-012 SHALL have port clear  in  1  returns to idle from a terminal state.
REQ-013 SHALL have port state  out  3  encoded FSM state.
REQ-014 SHALL have port done, pass, fail  out  1 each  run status.
REQ-015 SHALL have port fail_code  out  2  0 = none, 1 = mismatch, 2 = timeout.
REQ-016 SHALL have port fail_idx  out  IDX_W  checkpoint index at failure.
REQ-017 SHALL have port got_val  out  WIDTH  disp_dat captured at mismatch.
REQ-018 SHALL have port cycle_cnt  out  WIDTH  cycles spent in RUN.

Function
REQ-019 SHALL implement FSM states IDLE=0, RUN=1, PASS=2, FAIL=3.
REQ-020 IDLE: start=1 SHALL go to RUN, and SHALL clear the checkpoint index, cycle_cnt, fail_code, fail_idx and got_val.
REQ-021 RUN: each cycle cycle_cnt SHALL increment, saturating at all-ones.
REQ-022 RUN: a hit SHALL be pc[ADDR_W-1:0] == chk_pc[idx]; only the current index is compared, so out-of-order hits are ignored.
REQ-023 On a hit with disp_dat == chk_val[idx] and idx < NUM_CHK-1, idx SHALL increment, taking effect the next cycle.
REQ-024 On a hit with a matching value and idx == NUM_CHK-1, the next state SHALL be PASS.
REQ-025 On a hit with a differing value, the next state SHALL be FAIL with fail_code=1, fail_idx=idx and got_val=disp_dat.
REQ-026 Latency: pass or fail SHALL be asserted on the first rising edge after the hit cycle.
REQ-027 If the next checkpoint address equals the current PC, it SHALL be evaluated on the following cycle.
REQ-028 PASS and FAIL SHALL hold all outputs until clear=1, which goes to IDLE; clear SHALL have no effect in IDLE or RUN.
REQ-029 start SHALL be ignored outside IDLE.
REQ-030 done SHALL be 1 in PASS or FAIL; pass SHALL be 1 only in PASS; fail SHALL be 1 only in FAIL.
REQ-031 All outputs SHALL be registered.

Reset
REQ-032 reset=0 SHALL immediately force IDLE and zero every output and the internal index, including mid-RUN.
REQ-033 After reset is released, no run SHALL begin until start=1.

Configuration
REQ-034 Macro RUN_MON_TIMEOUT_EN SHALL control the watchdog.
- Defined: in RUN, when cycle_cnt reaches TIMEOUT-1 with no hit in that cycle, the next state SHALL be FAIL with fail_code=2 and fail_idx=idx.
- Defined: a hit in that same cycle SHALL take priority over the timeout.
- Undefined: no timeout logic SHALL exist and fail_code SHALL never be 2.

Verification
REQ-035 NUM_CHK=1, chk_pc=0x10, chk_val=24, start; hold pc=0x0C for 3 cycles, then pc=0x10 with disp_dat=24 -> pass=1, done=1 and fail_code=0 on the next edge.
REQ-036 Same setup with disp_dat=23 at pc=0x10 -> fail=1, fail_code=1, fail_idx=0, got_val=23.
REQ-037 NUM_CHK=2, chk_pc={0x20,0x10}, chk_val={7,24}:
- pc=0x20 first -> ignored.
- Then pc=0x10 with 24, then pc=0x20 with 7 -> PASS.
REQ-038 RUN_MON_TIMEOUT_EN, TIMEOUT=100, pc never hits -> FAIL with fail_code=2 and cycle_cnt=100.
REQ-039 Assert reset=0 mid-RUN after 5 cycles -> state=0 and all outputs 0 without waiting for a clock edge.
REQ-040 In PASS, pulse start -> no change; pulse clear -> IDLE; a fresh start then repeats REQ-035 and passes.
